// File: rtl/clause_regbank_ctrl_if.sv
// Bundle of lane requests, bank controls and the downstream chunk stream for
// clause_regbank_ctrl.
//   master : environment side; drives start, eval_done, req_valid, req_idx, out_ready
//   slave  : controller side; drives grants, bank write/read controls, stream flags,
//            busy and err_oob
interface clause_regbank_ctrl_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 11,
    parameter int unsigned ADDR_W  = 6
);
    logic                     start;
    logic                     eval_done;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_idx;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     bank_clr;
    logic                     write_mode;
    logic [31:0]              clause_chunk;
    logic [31:0]              clause_pos;
    logic                     stop_flag_1;
    logic                     read_mode;
    logic [ADDR_W-1:0]        read_addr;
    logic                     stop_flag_2;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic                     err_oob;

    modport master (
        output start, eval_done, req_valid, req_idx, out_ready,
        input  req_ready, bank_clr, write_mode, clause_chunk, clause_pos, stop_flag_1,
               read_mode, read_addr, stop_flag_2, out_valid, out_last, busy, err_oob
    );

    modport slave (
        input  start, eval_done, req_valid, req_idx, out_ready,
        output req_ready, bank_clr, write_mode, clause_chunk, clause_pos, stop_flag_1,
               read_mode, read_addr, stop_flag_2, out_valid, out_last, busy, err_oob
    );
endinterface

// File: rtl/clause_regbank_ctrl.sv
// Sequencer for the clause output register bank.
// Clears the bank once per inference, turns fired-clause reports from NUM_REQ
// evaluation lanes into single-cycle set-bit writes (round-robin, one grant per
// cycle), then drains every chunk in address order over a valid/ready stream.
// Ports:
//   clk      : clock
//   rst_flag : asynchronous active-high reset (also resets the bank at top level)
//   bus      : clause_regbank_ctrl_if.slave
//              start/eval_done control, lane req_valid/req_idx/req_ready,
//              bank write side (write_mode, clause_chunk, clause_pos, stop_flag_1),
//              bank read side (read_mode, read_addr, stop_flag_2), bank_clr,
//              stream (out_valid, out_last, out_ready), busy, err_oob
module clause_regbank_ctrl #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned CLAUSE_CHUNKS = 63,
    parameter int unsigned IDX_W         = 11,
    parameter int unsigned ADDR_W        = 6
) (
    input logic                  clk,
    input logic                  rst_flag,
    clause_regbank_ctrl_if.slave bus
);
    localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BANK_BITS = CLAUSE_CHUNKS * 32;

    typedef enum logic [1:0] {StIdle, StClear, StCollect, StRead} state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  rr_q;        // lane with highest priority this cycle
    logic [ADDR_W-1:0] rd_ptr_q;    // next bank address to issue
    logic              bank_clr_q;
    logic              stop1_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              err_oob_q;

    // Round-robin arbitration, combinational so the write lands at the next edge.
    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_lane;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_in_range;
    int unsigned       lane;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_lane = '0;
        lane     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            lane = 32'(rr_q) + k;
            if (lane >= NUM_REQ) begin
                lane = lane - NUM_REQ;
            end
            if (!gnt_any && bus.req_valid[PTR_W'(lane)]) begin
                gnt_any  = 1'b1;
                gnt_lane = PTR_W'(lane);
            end
        end
        if (state_q != StCollect) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt_idx      = bus.req_idx[32'(gnt_lane) * IDX_W +: IDX_W];
    assign gnt_in_range = (32'(gnt_idx) < BANK_BITS);

    // Read side: a presented chunk not taken downstream freezes the bank output.
    logic stall;
    logic issue;

    assign stall = out_valid_q & ~bus.out_ready;
    assign issue = (state_q == StRead) && !stall && (32'(rd_ptr_q) < CLAUSE_CHUNKS);

    always_comb begin
        bus.req_ready    = '0;
        bus.write_mode   = 1'b0;
        bus.clause_chunk = '0;
        bus.clause_pos   = '0;
        if (gnt_any) begin
            bus.req_ready    = NUM_REQ'(1) << gnt_lane;
            // Out-of-range reports are consumed but never written.
            bus.write_mode   = gnt_in_range;
            bus.clause_chunk = 32'(gnt_idx >> 5);
            bus.clause_pos   = 32'(gnt_idx[4:0]);
        end
    end

    assign bus.bank_clr    = bank_clr_q;
    assign bus.stop_flag_1 = stop1_q;
    assign bus.read_mode   = (state_q == StRead);
    assign bus.read_addr   = rd_ptr_q;
    assign bus.stop_flag_2 = (state_q != StRead) | stall;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.err_oob     = err_oob_q;

    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            rd_ptr_q    <= '0;
            bank_clr_q  <= 1'b0;
            stop1_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q    <= StClear;
                        err_oob_q  <= 1'b0;
                        bank_clr_q <= 1'b1;
                        rr_q       <= '0;
                    end
                end
                StClear: begin
                    state_q    <= StCollect;
                    bank_clr_q <= 1'b0;
                    stop1_q    <= 1'b0;
                end
                StCollect: begin
                    if (gnt_any) begin
                        rr_q <= (32'(gnt_lane) == NUM_REQ - 1) ? '0 : gnt_lane + 1'b1;
                        if (!gnt_in_range) begin
                            err_oob_q <= 1'b1;
                        end
                    end
                    if (bus.eval_done && (bus.req_valid == '0)) begin
                        state_q <= StRead;
                        stop1_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (issue) begin
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rd_ptr_q == ADDR_W'(CLAUSE_CHUNKS - 1));
                    end else if (!stall) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    if (out_valid_q && out_last_q && bus.out_ready) begin
                        state_q     <= StIdle;
                        rd_ptr_q    <= '0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_regbank_ctrl.sv
// Self-checking bench for clause_regbank_ctrl: a behavioural bank plus a
// reference model of the expected bank contents, grant order and err_oob.
module tb_clause_regbank_ctrl;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CHUNKS  = 63;
    localparam int unsigned IDX_W   = 11;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned MAXQ    = 16;

    logic clk = 1'b0;
    logic rst_flag;
    always #5 clk = ~clk;

    clause_regbank_ctrl_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    clause_regbank_ctrl #(
        .NUM_REQ      (NUM_REQ),
        .CLAUSE_CHUNKS(CHUNKS),
        .IDX_W        (IDX_W),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_flag(rst_flag),
        .bus     (bus)
    );

    // Behavioural register bank driven by the controller outputs.
    logic [31:0] bank [CHUNKS];
    logic [31:0] output_clause;

    always @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            for (int i = 0; i < CHUNKS; i++) bank[i] <= '0;
            output_clause <= '0;
        end else begin
            if (bus.bank_clr) begin
                for (int i = 0; i < CHUNKS; i++) bank[i] <= '0;
            end else if (bus.write_mode && bus.clause_chunk < CHUNKS) begin
                bank[bus.clause_chunk][bus.clause_pos[4:0]] <= 1'b1;
            end
            if (bus.read_mode && !bus.stop_flag_2 && bus.read_addr < CHUNKS) begin
                output_clause <= bank[bus.read_addr];
            end
        end
    end

    // Reference model state.
    logic [31:0] exp_bank [CHUNKS];
    bit          exp_oob;
    int unsigned rr_model;
    int unsigned lane_idx  [NUM_REQ][MAXQ];
    int unsigned lane_cnt  [NUM_REQ];
    int unsigned lane_head [NUM_REQ];

    int vectors    = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_cnt[i]  = 0;
            lane_head[i] = 0;
        end
    endtask

    task automatic push_lane(input int unsigned l, input int unsigned idx);
        lane_idx[l][lane_cnt[l]] = idx;
        lane_cnt[l]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) if (lane_head[i] < lane_cnt[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        vectors++;
        if ({bus.bank_clr, bus.busy, bus.err_oob, bus.write_mode, bus.read_mode} !== 5'b11000) begin
            miscompares++;
            $display("FAIL start_clear: got clr/busy/oob/wm/rm=%b want 11000",
                     {bus.bank_clr, bus.busy, bus.err_oob, bus.write_mode, bus.read_mode});
        end
        for (int i = 0; i < CHUNKS; i++) exp_bank[i] = '0;
        exp_oob  = 1'b0;
        rr_model = 0;
        tick();
        #1;
        vectors++;
        if ({bus.bank_clr, bus.stop_flag_1, bus.stop_flag_2} !== 3'b001) begin
            miscompares++;
            $display("FAIL collect_entry: got clr/sf1/sf2=%b want 001",
                     {bus.bank_clr, bus.stop_flag_1, bus.stop_flag_2});
        end
    endtask

    // Drives queued lane reports, checks every grant against the model, then
    // raises eval_done and checks the move into READ.
    task automatic run_collect(input bit early_done, input bit gaps);
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] exp_ready;
        int unsigned        g, idx, l;
        bit                 exp_wm;
        int                 guard;
        guard = 0;
        bus.eval_done = early_done;
        while (pending() && guard < 400) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                v[i] = (lane_head[i] < lane_cnt[i]) && (!gaps || $urandom_range(0, 3) != 0);
                if (lane_head[i] < lane_cnt[i])
                    bus.req_idx[i*IDX_W +: IDX_W] = IDX_W'(lane_idx[i][lane_head[i]]);
                else
                    bus.req_idx[i*IDX_W +: IDX_W] = IDX_W'($urandom);
            end
            bus.req_valid = v;
            bus.start     = 1'($urandom_range(0, 1));
            #1;
            exp_ready = '0;
            exp_wm    = 1'b0;
            g         = 0;
            idx       = 0;
            if (v != '0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    l = (rr_model + k) % NUM_REQ;
                    if (v[l]) g = l;
                end
                idx = lane_idx[g][lane_head[g]];
                exp_ready[g] = 1'b1;
                exp_wm = (idx < CHUNKS * 32);
            end
            vectors++;
            if ({bus.req_ready, bus.write_mode, bus.read_mode, bus.stop_flag_1, bus.bank_clr,
                 bus.err_oob} !== {exp_ready, exp_wm, 3'b000, exp_oob}) begin
                miscompares++;
                $display("FAIL collect_grant: got rdy=%b wm=%b rm/sf1/clr=%b oob=%b want rdy=%b wm=%b rm/sf1/clr=000 oob=%b",
                         bus.req_ready, bus.write_mode,
                         {bus.read_mode, bus.stop_flag_1, bus.bank_clr}, bus.err_oob,
                         exp_ready, exp_wm, exp_oob);
            end
            if (v != '0) begin
                vectors++;
                if ({bus.clause_chunk, bus.clause_pos} !== {idx / 32, idx % 32}) begin
                    miscompares++;
                    $display("FAIL collect_addr: got chunk=%0d pos=%0d want chunk=%0d pos=%0d",
                             bus.clause_chunk, bus.clause_pos, idx / 32, idx % 32);
                end
                if (exp_wm) exp_bank[idx / 32][idx % 32] = 1'b1;
                else exp_oob = 1'b1;
                lane_head[g]++;
                rr_model = (g + 1) % NUM_REQ;
            end
            tick();
            guard++;
        end
        bus.start     = 1'b0;
        bus.req_valid = '0;
        bus.eval_done = 1'b1;
        #1;
        vectors++;
        if ({bus.read_mode, bus.stop_flag_1, bus.req_ready, bus.err_oob} !==
            {2'b00, {NUM_REQ{1'b0}}, exp_oob} || guard >= 400) begin
            miscompares++;
            $display("FAIL collect_last: got rm=%b sf1=%b rdy=%b oob=%b guard=%0d want rm=0 sf1=0 rdy=0 oob=%b",
                     bus.read_mode, bus.stop_flag_1, bus.req_ready, bus.err_oob, guard, exp_oob);
        end
        tick();
        bus.eval_done = 1'b0;
        #1;
        vectors++;
        if ({bus.read_mode, bus.stop_flag_1, bus.read_addr, bus.out_valid, bus.write_mode} !==
            {2'b11, 6'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL read_entry: got rm=%b sf1=%b addr=%0d ov=%b wm=%b want rm=1 sf1=1 addr=0 ov=0 wm=0",
                     bus.read_mode, bus.stop_flag_1, bus.read_addr, bus.out_valid, bus.write_mode);
        end
    endtask

    // mode 0: out_ready held 1; 1: pattern 1,0,0 repeating; 2: random.
    task automatic drain(input int mode);
        int          word, cyc, first_cyc, last_cyc;
        bit          was_stall, rdy;
        logic [31:0] held;
        word = 0; cyc = 0; first_cyc = -1; last_cyc = -1; was_stall = 0; held = '0;
        while (word < CHUNKS && cyc < 400) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            bus.eval_done = 1'($urandom_range(0, 1));
            bus.start     = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if ({bus.out_valid, bus.stop_flag_2, bus.busy, bus.write_mode} !==
                {cyc != 0, (cyc != 0) && !rdy, 2'b10}) begin
                miscompares++;
                $display("FAIL drain_flags: cyc=%0d got ov=%b sf2=%b busy=%b wm=%b want ov=%b sf2=%b busy=1 wm=0",
                         cyc, bus.out_valid, bus.stop_flag_2, bus.busy, bus.write_mode,
                         cyc != 0, (cyc != 0) && !rdy);
            end
            if (was_stall) begin
                vectors++;
                if (output_clause !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: word=%0d got %h want %h", word, output_clause, held);
                end
            end
            if (bus.out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                vectors++;
                if ({output_clause, bus.out_last, bus.read_addr} !==
                    {exp_bank[word], word == CHUNKS - 1, 6'(word + 1)}) begin
                    miscompares++;
                    $display("FAIL drain_word: word=%0d got data=%h last=%b addr=%0d want data=%h last=%b addr=%0d",
                             word, output_clause, bus.out_last, bus.read_addr,
                             exp_bank[word], word == CHUNKS - 1, word + 1);
                end
                if (rdy) begin
                    word++;
                    last_cyc  = cyc;
                    was_stall = 1'b0;
                end else begin
                    was_stall = 1'b1;
                    held      = output_clause;
                end
            end
            tick();
            cyc++;
        end
        bus.start     = 1'b0;
        bus.eval_done = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.read_mode, bus.out_valid, bus.stop_flag_1, bus.stop_flag_2,
             bus.err_oob} !== {5'b00011, exp_oob} || word != CHUNKS) begin
            miscompares++;
            $display("FAIL drain_end: words=%0d got busy=%b rm=%b ov=%b sf1=%b sf2=%b oob=%b want words=%0d 00011 oob=%b",
                     word, bus.busy, bus.read_mode, bus.out_valid, bus.stop_flag_1,
                     bus.stop_flag_2, bus.err_oob, CHUNKS, exp_oob);
        end
        if (mode == 0) begin
            vectors++;
            if (first_cyc != 1 || last_cyc - first_cyc != CHUNKS - 1) begin
                miscompares++;
                $display("FAIL drain_rate: got first=%0d last=%0d want first=1 last=%0d",
                         first_cyc, last_cyc, CHUNKS);
            end
        end
    endtask

    task automatic test_reset();
        rst_flag      = 1'b1;
        bus.start     = 1'b0;
        bus.eval_done = 1'b0;
        bus.req_valid = '0;
        bus.req_idx   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.req_ready, bus.bank_clr, bus.write_mode, bus.read_mode, bus.clause_chunk,
             bus.clause_pos, bus.read_addr, bus.stop_flag_1, bus.stop_flag_2, bus.out_valid,
             bus.out_last, bus.busy, bus.err_oob} !== {4'b0, 3'b0, 64'b0, 6'b0, 2'b11, 4'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b clr=%b wm=%b rm=%b chunk=%0d pos=%0d addr=%0d sf1=%b sf2=%b ov=%b ol=%b busy=%b oob=%b",
                     bus.req_ready, bus.bank_clr, bus.write_mode, bus.read_mode,
                     bus.clause_chunk, bus.clause_pos, bus.read_addr, bus.stop_flag_1,
                     bus.stop_flag_2, bus.out_valid, bus.out_last, bus.busy, bus.err_oob);
        end
        rst_flag = 1'b0;
        tick();
    endtask

    task automatic test_grant_order();
        do_start();
        clear_lanes();
        push_lane(0, 5);
        push_lane(1, 37);
        push_lane(2, 64);
        push_lane(3, 2015);
        run_collect(1'b0, 1'b0);
        drain(0);
    endtask

    task automatic test_fairness();
        do_start();
        clear_lanes();
        for (int i = 0; i < 8; i++) begin
            push_lane(0, $urandom_range(0, CHUNKS * 32 - 1));
            push_lane(2, $urandom_range(0, CHUNKS * 32 - 1));
        end
        run_collect(1'b0, 1'b0);
        drain(1);
    endtask

    task automatic test_oob();
        do_start();
        clear_lanes();
        push_lane(1, 2016);
        push_lane(3, 100);
        push_lane(3, 2047);
        run_collect(1'b0, 1'b0);
        drain(2);
    endtask

    task automatic test_eval_done_pending();
        do_start();
        clear_lanes();
        push_lane(2, $urandom_range(0, CHUNKS * 32 - 1));
        run_collect(1'b1, 1'b0);
        drain(0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_start();
            clear_lanes();
            for (int l = 0; l < NUM_REQ; l++) begin
                int n;
                n = $urandom_range(0, 6);
                for (int j = 0; j < n; j++) push_lane(l, $urandom_range(0, 2047));
            end
            run_collect(1'b0, 1'b1);
            drain(2);
        end
    endtask

    task automatic test_reset_mid_read();
        do_start();
        clear_lanes();
        push_lane(0, 33);
        push_lane(3, 1000);
        run_collect(1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_flag = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.bank_clr, bus.write_mode, bus.read_mode, bus.clause_chunk,
             bus.clause_pos, bus.read_addr, bus.stop_flag_1, bus.stop_flag_2, bus.out_valid,
             bus.out_last, bus.busy, bus.err_oob} !== {4'b0, 3'b0, 64'b0, 6'b0, 2'b11, 4'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_read: got rm=%b addr=%0d sf1=%b sf2=%b ov=%b ol=%b busy=%b",
                     bus.read_mode, bus.read_addr, bus.stop_flag_1, bus.stop_flag_2,
                     bus.out_valid, bus.out_last, bus.busy);
        end
        bus.out_ready = 1'b0;
        tick();
        #2;
        rst_flag = 1'b0;
        tick();
        do_start();
        clear_lanes();
        push_lane(1, 7);
        push_lane(2, 1500);
        push_lane(2, 31);
        run_collect(1'b0, 1'b0);
        drain(0);
    endtask

    initial begin
        rst_flag = 1'b1;
        test_reset();
        test_grant_order();
        test_fairness();
        test_oob();
        test_eval_done_pending();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
